// File: rtl/wb_write_arbiter_if.sv
// Writeback bus between the ALU/memory writeback sources and the register-file write port.
// The arbiter takes the slave side; the producer/consumer environment takes the master side.
interface wb_write_arbiter_if #(
  parameter int unsigned DATA_W = 16
);
  logic              alu_wr_en;
  logic [3:0]        alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              mem_wr_valid;
  logic              mem_wr_ready;
  logic [3:0]        mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              wr_en;
  logic [3:0]        wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic [15:0]       mem_pending;

  modport master (
    output alu_wr_en, alu_reg, alu_data,
    output mem_wr_valid, mem_reg, mem_data,
    input  mem_wr_ready,
    input  wr_en, wr_reg, wr_data, mem_pending
  );

  modport slave (
    input  alu_wr_en, alu_reg, alu_data,
    input  mem_wr_valid, mem_reg, mem_data,
    output mem_wr_ready,
    output wr_en, wr_reg, wr_data, mem_pending
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Merges ALU and memory writebacks onto the single register-file write port.
// Losing memory writes wait in a 2-entry FIFO; an ALU write retires older queued writes to the same register.
module wb_write_arbiter #(
  parameter int unsigned DATA_W = 16
) (
  input logic             clk,
  input logic             rst,
  wb_write_arbiter_if.slave bus
);

  logic              ent_live [2];
  logic [3:0]        ent_reg  [2];
  logic [DATA_W-1:0] ent_data [2];
  logic              head;
  logic              tail;
  logic [1:0]        count;

  logic              out_en;
  logic [3:0]        out_reg;
  logic [DATA_W-1:0] out_data;

  logic              ready;
  logic              accept;
  logic              alu_hit;
  logic              mem_nz;
  logic              fifo_ne;
  logic              do_pop;
  logic              do_bypass;
  logic              do_push;
  logic              push_live;
  logic [1:0]        ent_valid;
  logic [15:0]       pending;

  // Full FIFO never pushes in a pop cycle: ready depends on count alone.
  assign ready     = ~rst & (count < 2'd2);
  assign accept    = bus.mem_wr_valid & ready;
  assign alu_hit   = bus.alu_wr_en & (bus.alu_reg != 4'd0);
  assign mem_nz    = bus.mem_reg != 4'd0;
  assign fifo_ne   = count != 2'd0;
  assign do_pop    = ~alu_hit & fifo_ne;
  assign do_bypass = ~alu_hit & ~fifo_ne & accept & mem_nz;
  assign do_push   = accept & mem_nz & ~do_bypass;
  // The ALU write is younger, so a same-register memory write arriving with it is already stale.
  assign push_live = ~(alu_hit & (bus.alu_reg == bus.mem_reg));

  always_comb begin
    ent_valid = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      ent_valid[i] = (count == 2'd2) || ((count == 2'd1) && (head == i[0]));
    end
  end

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (ent_valid[i] && ent_live[i]) begin
        pending[ent_reg[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= 1'b0;
      tail     <= 1'b0;
      count    <= '0;
      out_en   <= 1'b0;
      out_reg  <= '0;
      out_data <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        ent_live[i] <= 1'b0;
        ent_reg[i]  <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (alu_hit) begin
        for (int unsigned i = 0; i < 2; i++) begin
          if (ent_reg[i] == bus.alu_reg) begin
            ent_live[i] <= 1'b0;
          end
        end
      end

      if (alu_hit) begin
        out_en   <= 1'b1;
        out_reg  <= bus.alu_reg;
        out_data <= bus.alu_data;
      end else if (do_pop) begin
        // A killed entry drains as a bubble and leaves the last write on the port untouched.
        out_en <= ent_live[head];
        if (ent_live[head]) begin
          out_reg  <= ent_reg[head];
          out_data <= ent_data[head];
        end
      end else if (do_bypass) begin
        out_en   <= 1'b1;
        out_reg  <= bus.mem_reg;
        out_data <= bus.mem_data;
      end else begin
        out_en <= 1'b0;
      end

      if (do_push) begin
        ent_live[tail] <= push_live;
        ent_reg[tail]  <= bus.mem_reg;
        ent_data[tail] <= bus.mem_data;
        tail           <= ~tail;
      end
      if (do_pop) begin
        head <= ~head;
      end

      if (do_push && !do_pop) begin
        count <= count + 2'd1;
      end else if (do_pop && !do_push) begin
        count <= count - 2'd1;
      end
    end
  end

  assign bus.mem_wr_ready = ready;
  assign bus.wr_en        = out_en;
  assign bus.wr_reg       = out_reg;
  assign bus.wr_data      = out_data;
  assign bus.mem_pending  = pending;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference model.
module tb_wb_write_arbiter;

  logic clk;
  logic rst;
  wb_write_arbiter_if #(.DATA_W(16)) bus ();

  wb_write_arbiter #(.DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        live;
    bit [3:0]  r;
    bit [15:0] d;
  } ent_t;

  ent_t      q[$];
  bit        m_en;
  bit [3:0]  m_reg;
  bit [15:0] m_data;

  int        checks;
  int        failures;
  bit        started;
  logic      last_ready;
  logic [15:0] shadow [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [15:0] model_pending();
    bit [15:0] p = '0;
    foreach (q[i]) if (q[i].live) p[q[i].r] = 1'b1;
    return p;
  endfunction

  // Reference: writes are a queue of pending memory results; the ALU always wins the port.
  task automatic model_step();
    bit acc, alu, byp;
    ent_t e;
    if (rst) begin
      q.delete();
      m_en = 0; m_reg = 0; m_data = 0;
      return;
    end
    acc = bus.mem_wr_valid && (q.size() < 2);
    alu = bus.alu_wr_en && (bus.alu_reg != 0);
    byp = 0;
    if (alu) foreach (q[i]) if (q[i].r == bus.alu_reg) q[i].live = 0;
    if (alu) begin
      m_en = 1; m_reg = bus.alu_reg; m_data = bus.alu_data;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_en = e.live;
      if (e.live) begin m_reg = e.r; m_data = e.d; end
    end else if (acc && bus.mem_reg != 0) begin
      byp = 1;
      m_en = 1; m_reg = bus.mem_reg; m_data = bus.mem_data;
    end else begin
      m_en = 0;
    end
    if (acc && bus.mem_reg != 0 && !byp) begin
      e.live = !(alu && bus.alu_reg == bus.mem_reg);
      e.r = bus.mem_reg;
      e.d = bus.mem_data;
      q.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("wr_en", bus.wr_en, m_en);
      chk("wr_reg", bus.wr_reg, m_reg);
      chk("wr_data", bus.wr_data, m_data);
      chk("mem_pending", bus.mem_pending, model_pending());
      chk("mem_wr_ready", bus.mem_wr_ready, (!rst && q.size() < 2));
      if (bus.wr_en === 1'b1) shadow[bus.wr_reg] = bus.wr_data;
    end
  end

  // One request cycle: outputs reflect this request when the task returns.
  task automatic cyc(input bit ae, input bit [3:0] ar, input bit [15:0] ad,
                     input bit mv, input bit [3:0] mr, input bit [15:0] md);
    bus.alu_wr_en = ae; bus.alu_reg = ar; bus.alu_data = ad;
    bus.mem_wr_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
    @(negedge clk);
    last_ready = bus.mem_wr_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    checks = 0; failures = 0; started = 0;
    foreach (shadow[i]) shadow[i] = '0;
    rst = 1'b1;
    bus.alu_wr_en = 0; bus.alu_reg = 0; bus.alu_data = 0;
    bus.mem_wr_valid = 0; bus.mem_reg = 0; bus.mem_data = 0;

    // Reset and ALU path
    idle();
    started = 1;
    idle();
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_reg", bus.wr_reg, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_pending", bus.mem_pending, 0);
    chk("rst_ready", bus.mem_wr_ready, 0);
    rst = 1'b0;
    cyc(1, 5, 16'hBEEF, 0, 0, 0);
    chk("post_rst_ready", last_ready, 1);
    chk("alu_en", bus.wr_en, 1);
    chk("alu_reg", bus.wr_reg, 5);
    chk("alu_data", bus.wr_data, 16'hBEEF);

    // Bypass
    cyc(0, 0, 0, 1, 3, 16'h1234);
    chk("byp_accept", last_ready, 1);
    chk("byp_en", bus.wr_en, 1);
    chk("byp_reg", bus.wr_reg, 3);
    chk("byp_data", bus.wr_data, 16'h1234);
    chk("byp_pending", bus.mem_pending, 0);

    // Contention and queueing
    cyc(1, 1, 16'h0101, 1, 7, 16'h0707);
    chk("q1_pending", bus.mem_pending, 16'h0080);
    cyc(1, 1, 16'h0102, 1, 9, 16'h0909);
    chk("q2_pending", bus.mem_pending, 16'h0280);
    chk("q2_model_pending", model_pending(), 16'h0280);
    chk("q2_ready", bus.mem_wr_ready, 0);
    cyc(1, 1, 16'h0103, 1, 11, 16'h0B0B);
    chk("full_ready", last_ready, 0);
    idle();
    chk("drain7_en", bus.wr_en, 1);
    chk("drain7_reg", bus.wr_reg, 7);
    chk("drain7_data", bus.wr_data, 16'h0707);
    idle();
    chk("drain9_reg", bus.wr_reg, 9);
    chk("drain9_data", bus.wr_data, 16'h0909);
    chk("drain_pending", bus.mem_pending, 0);

    // Ordering kill
    cyc(1, 2, 16'h0202, 1, 4, 16'h4444);
    chk("k_pending", bus.mem_pending, 16'h0010);
    cyc(1, 4, 16'hAAAA, 0, 0, 0);
    chk("k_cleared", bus.mem_pending, 0);
    chk("k_alu_data", bus.wr_data, 16'hAAAA);
    idle();
    chk("k_bubble", bus.wr_en, 0);
    idle();
    chk("k_last_r4", shadow[4], 16'hAAAA);

    // R0 and same-cycle conflict
    cyc(0, 0, 0, 1, 0, 16'h5555);
    chk("r0_mem_accept", last_ready, 1);
    chk("r0_mem_en", bus.wr_en, 0);
    chk("r0_mem_pending", bus.mem_pending, 0);
    cyc(1, 0, 16'h7777, 0, 0, 0);
    chk("r0_alu_en", bus.wr_en, 0);
    cyc(1, 1, 16'h0104, 1, 8, 16'h8888);
    cyc(1, 6, 16'h6A6A, 1, 6, 16'h6B6B);
    chk("sc_data", bus.wr_data, 16'h6A6A);
    chk("sc_pending", bus.mem_pending, 16'h0100);
    chk("sc_model_len", q.size(), 2);
    idle();
    chk("sc_drain8", bus.wr_reg, 8);
    idle();
    chk("sc_dead6", bus.wr_en, 0);
    idle();
    chk("sc_last_r6", shadow[6], 16'h6A6A);

    // Reset mid-queue
    cyc(1, 1, 16'h0105, 1, 10, 16'hA0A0);
    cyc(1, 1, 16'h0106, 1, 12, 16'hC0C0);
    chk("mq_pending", bus.mem_pending, 16'h1400);
    rst = 1'b1;
    idle();
    chk("mq_rst_pending", bus.mem_pending, 0);
    chk("mq_rst_en", bus.wr_en, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("mq_no_issue", bus.wr_en, 0);
    end
    chk("mq_ready", bus.mem_wr_ready, 1);

    // Randomized traffic; the compare process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      cyc($urandom_range(0, 1), 4'($urandom_range(0, 5)), 16'($urandom),
          $urandom_range(0, 1), 4'($urandom_range(0, 5)), 16'($urandom));
    end
    rst = 1'b0;
    repeat (4) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
